// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter
// Measures the period and high time of an asynchronous divided clock (sig_in)
// in whole clk_in cycles. sig_in is synchronized by two flops and edge-detected
// against a third. A two-state FSM counts cycles between rising edges, captures
// the count on each rise and flags a sticky overflow when the count saturates.
// Optional feature macro: CLK_METER_LOCK_EN builds the stable-period lock
// counter; without it `locked` is constant 0.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module clk_ratio_meter #(
    parameter int WIDTH      = `DATA_WIDTH,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             overflow,
    output logic             locked
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(1'b0);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    // Count value at which the next cycle without a rise would saturate.
    localparam logic [WIDTH-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

    logic             sync1_r;
    logic             sync2_r;
    logic             prev_r;
    logic             rise_s;
    logic             fall_s;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] cand_r;
    logic [WIDTH-1:0] cand_s;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] period_s;
    logic [WIDTH-1:0] high_r;
    logic [WIDTH-1:0] high_s;
    logic             valid_r;
    logic             valid_s;
    logic             ovf_r;
    logic             ovf_s;

    // Two-flop synchronizer plus edge register; keeps running while en is low.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rise_s = sync2_r & ~prev_r;
    assign fall_s = ~sync2_r & prev_r;

    // Next-state and capture logic; en low and a rise both outrank saturation.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        cand_s   = cand_r;
        period_s = period_r;
        high_s   = high_r;
        valid_s  = 1'b0;
        ovf_s    = ovf_r;
        if (!en) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        cnt_s   = CNT_ONE;
                        state_s = ST_MEASURE;
                    end else begin
                        cnt_s   = cnt_r;
                    end
                end
                ST_MEASURE: begin
                    if (rise_s) begin
                        period_s = cnt_r;
                        high_s   = cand_r;
                        valid_s  = 1'b1;
                        cnt_s    = CNT_ONE;
                    end else begin
                        if (fall_s) begin
                            cand_s = cnt_r;
                        end else begin
                            cand_s = cand_r;
                        end
                        if (cnt_r >= CNT_NEAR) begin
                            cnt_s   = CNT_MAX;
                            ovf_s   = 1'b1;
                            state_s = ST_IDLE;
                        end else begin
                            cnt_s   = cnt_r + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Measurement state and registered results.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            cand_r   <= CNT_ZERO;
            period_r <= CNT_ZERO;
            high_r   <= CNT_ZERO;
            valid_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            cand_r   <= cand_s;
            period_r <= period_s;
            high_r   <= high_s;
            valid_r  <= valid_s;
            ovf_r    <= ovf_s;
        end
    end

    assign period    = period_r;
    assign high_time = high_r;
    assign valid     = valid_r;
    assign overflow  = ovf_r;

`ifdef CLK_METER_LOCK_EN
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [LW-1:0] LOCK_FULL = LW'(LOCK_COUNT);
    localparam logic [LW-1:0] LOCK_ONE  = LW'(1'b1);
    localparam logic [LW-1:0] LOCK_ZERO = LW'(1'b0);

    logic          capture_s;
    logic          abort_s;
    logic [LW-1:0] lock_cnt_r;
    logic [LW-1:0] lock_cnt_s;
    logic          locked_r;
    logic          locked_s;

    // A capture compares the new period (cnt_r) with the one still on period_r.
    assign capture_s = en & (state_r == ST_MEASURE) & rise_s;
    assign abort_s   = ~en | ((state_r == ST_MEASURE) & ~rise_s & (cnt_r >= CNT_NEAR));

    // Lock counter: saturating run length of identical consecutive periods.
    always_comb begin
        lock_cnt_s = lock_cnt_r;
        if (abort_s) begin
            lock_cnt_s = LOCK_ZERO;
        end else if (capture_s) begin
            if (cnt_r == period_r) begin
                if (lock_cnt_r < LOCK_FULL) begin
                    lock_cnt_s = lock_cnt_r + LOCK_ONE;
                end else begin
                    lock_cnt_s = lock_cnt_r;
                end
            end else begin
                lock_cnt_s = LOCK_ZERO;
            end
        end else begin
            lock_cnt_s = lock_cnt_r;
        end
        locked_s = (lock_cnt_s == LOCK_FULL);
    end

    // Lock counter and registered lock indication.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            lock_cnt_r <= LOCK_ZERO;
            locked_r   <= 1'b0;
        end else begin
            lock_cnt_r <= lock_cnt_s;
            locked_r   <= locked_s;
        end
    end

    assign locked = locked_r;
`else
    assign locked = 1'b0;
`endif

endmodule
